// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between IF and DM.
// DM has priority; a starvation counter periodically forces IF through.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  state_t     state;
  logic       owner_dm;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       idle;
  logic       if_force;

  assign idle     = rst && (state == IDLE);
  assign if_force = if_req && (starve_cnt == 4'(MAX_STARVE));
  assign dm_gnt   = idle && dm_req && !if_force;
  assign if_gnt   = idle && if_req && (!dm_req || if_force);
  assign busy     = (state != IDLE);
  assign if_stall = if_req && !if_rvalid;
  assign dm_stall = dm_req && !dm_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner_dm   <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      mem_en    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_gnt) begin
            starve_cnt <= '0;
            owner_dm   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_en     <= 1'b1;
            state      <= ACCESS;
          end else if (dm_gnt) begin
            // a DM grant with IF waiting never happens at saturation
            starve_cnt <= if_req ? starve_cnt + 4'd1 : '0;
            owner_dm   <= 1'b1;
            mem_we     <= dm_we;
            mem_addr   <= dm_addr;
            mem_wdata  <= dm_wdata;
            mem_en     <= 1'b1;
            state      <= ACCESS;
          end else begin
            starve_cnt <= '0;
          end
        end
        ACCESS: begin
          lat_cnt <= 4'(MEM_LAT - 1);
          state   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == 4'd0) begin
            if (!mem_we) begin
              if (owner_dm) dm_rdata <= mem_rdata;
              else          if_rdata <= mem_rdata;
            end
            if_rvalid <= !owner_dm;
            dm_rvalid <= owner_dm;
            state     <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed traffic against a
// transaction-level model of the arbiter and a latency-accurate memory.
module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int MAX_STARVE = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  mem_port_arbiter #(
    .AW(32), .DW(32), .MEM_LAT(MEM_LAT), .MAX_STARVE(MAX_STARVE)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h01234567;
  endfunction

  // memory: data only valid in the cycle MEM_LAT after the strobe
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] pend = '0;
  int          resp_cyc = -1;

  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_we) bmem[mem_addr] = mem_wdata;
      else pend = bmem.exists(mem_addr) ? bmem[mem_addr] : dflt(mem_addr);
      resp_cyc = cyc + MEM_LAT;
    end
    mem_rdata = (cyc == resp_cyc) ? pend : $urandom;
  end

  // reference model: one transaction in flight, fixed schedule from grant
  logic [31:0] ref_mem [logic [31:0]];
  int          free_at = 0;
  int          streak = 0;
  int          t_g = 0;
  bit          t_act = 0;
  bit          t_dm = 0;
  bit          t_we = 0;
  logic [31:0] t_addr = '0;
  logic [31:0] t_wd = '0;
  logic [31:0] t_rd = '0;
  logic [31:0] e_if_rd = '0;
  logic [31:0] e_dm_rd = '0;
  bit          m_idle, m_acc, m_rv;
  bit          m_if_gnt = 0;
  bit          m_dm_gnt = 0;
  int          cnt_ifg = 0;
  int          cnt_dmg = 0;
  int          cnt_dmrv = 0;
  logic [31:0] last_if_rd = '0;

  always @(negedge clk) begin
    if (if_gnt) cnt_ifg++;
    if (dm_gnt) cnt_dmg++;
    if (dm_rvalid) cnt_dmrv++;
    if (if_rvalid) last_if_rd = if_rdata;
    if (!rst) begin
      t_act = 0; free_at = cyc + 1; streak = 0;
      e_if_rd = '0; e_dm_rd = '0;
      m_if_gnt = 0; m_dm_gnt = 0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_if_gnt", 32'(if_gnt), 32'd0);
      chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
      chk("rst_if_rv", 32'(if_rvalid), 32'd0);
      chk("rst_dm_rv", 32'(dm_rvalid), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
    end else begin
      m_idle = (cyc >= free_at);
      m_if_gnt = 0; m_dm_gnt = 0;
      if (m_idle) begin
        if (dm_req && !(if_req && streak == MAX_STARVE)) m_dm_gnt = 1;
        else if (if_req) m_if_gnt = 1;
        if (m_if_gnt || !if_req) streak = 0;
        else if (streak < MAX_STARVE) streak++;
        if (m_if_gnt || m_dm_gnt) begin
          t_act = 1; t_dm = m_dm_gnt; t_we = m_dm_gnt && dm_we;
          t_addr = m_dm_gnt ? dm_addr : if_addr;
          t_wd = dm_wdata; t_g = cyc;
          free_at = cyc + MEM_LAT + 3;
        end
      end
      m_acc = t_act && (cyc == t_g + 1);
      if (m_acc) begin
        if (t_we) ref_mem[t_addr] = t_wd;
        else t_rd = ref_mem.exists(t_addr) ? ref_mem[t_addr] : dflt(t_addr);
      end
      m_rv = t_act && (cyc == t_g + 2 + MEM_LAT);
      if (m_rv && !t_we) begin
        if (t_dm) e_dm_rd = t_rd;
        else e_if_rd = t_rd;
      end
      chk("busy", 32'(busy), 32'(!m_idle));
      chk("if_gnt", 32'(if_gnt), 32'(m_if_gnt));
      chk("dm_gnt", 32'(dm_gnt), 32'(m_dm_gnt));
      chk("mem_en", 32'(mem_en), 32'(m_acc));
      chk("if_rvalid", 32'(if_rvalid), 32'(m_rv && !t_dm));
      chk("dm_rvalid", 32'(dm_rvalid), 32'(m_rv && t_dm));
      chk("if_rdata", if_rdata, e_if_rd);
      chk("dm_rdata", dm_rdata, e_dm_rd);
      chk("if_stall", 32'(if_stall), 32'(if_req && !(m_rv && !t_dm)));
      chk("dm_stall", 32'(dm_stall), 32'(dm_req && !(m_rv && t_dm)));
      if (t_act && cyc > t_g && cyc <= t_g + 2 + MEM_LAT) begin
        chk("mem_addr", mem_addr, t_addr);
        chk("mem_we", 32'(mem_we), 32'(t_we));
        if (t_we) chk("mem_wdata", mem_wdata, t_wd);
      end
    end
  end

  function automatic logic [31:0] raddr();
    return 32'h2000 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  task automatic step(input int pi, input int pd);
    @(posedge clk);
    #1;
    if (!if_req || m_if_gnt) begin
      if_req = ($urandom_range(0, 99) < pi);
      if_addr = raddr();
    end
    if (!dm_req || m_dm_gnt) begin
      dm_req = ($urandom_range(0, 99) < pd);
      dm_we = 1'($urandom_range(0, 1));
      dm_addr = raddr();
      dm_wdata = $urandom;
    end
  endtask

  int d0, i0, r0, pi, pd;

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    bmem[32'h100] = 32'h00500093;
    ref_mem[32'h100] = 32'h00500093;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) step(0, 0);

    if_req = 1; if_addr = 32'h100;
    repeat (8) step(0, 0);
    chk("dir_if_rd", last_if_rd, 32'h00500093);

    dm_req = 1; dm_we = 1; dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF;
    repeat (8) step(0, 0);
    chk("dir_st_mem", bmem[32'h2000], 32'hDEADBEEF);

    if_req = 1; if_addr = 32'h2000;
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    repeat (14) step(0, 0);
    chk("sim_if_rd", last_if_rd, 32'hDEADBEEF);

    repeat (10) step(0, 0);
    d0 = cnt_dmg; i0 = cnt_ifg;
    repeat (50) step(100, 100);
    chk("starve_dm", 32'(cnt_dmg - d0), 32'd8);
    chk("starve_if", 32'(cnt_ifg - i0), 32'd2);
    repeat (20) step(0, 0);

    dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    step(0, 0);
    step(0, 0);
    r0 = cnt_dmrv;
    rst = 1'b0;
    repeat (2) step(0, 0);
    rst = 1'b1;
    repeat (6) step(0, 0);
    chk("rst_no_rv", 32'(cnt_dmrv - r0), 32'd0);
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
    repeat (8) step(0, 0);
    chk("post_rst_ld", dm_rdata, 32'hDEADBEEF);

    pi = 50; pd = 50;
    for (int k = 0; k < 2400; k++) begin
      if (k % 200 == 0) begin
        pi = $urandom_range(5, 95);
        pd = $urandom_range(5, 95);
      end
      if (k % 800 == 799) begin
        rst = 1'b0;
        step(0, 0);
        rst = 1'b1;
      end else begin
        step(pi, pd);
      end
    end
    repeat (12) step(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
